// File: rtl/alu_pipelined.sv
// Two-stage pipelined ALU with valid/ready handshakes on input and output.
// S1 captures operands and opcode on accept; S2 registers the result.
// Optional status flags {neg, carry, zero} are enabled by defining the
// macro ALU_STATUS_FLAGS_EN; without it the flags port and logic are absent.
module alu_pipelined #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned SHAMT_A = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] y
`ifdef ALU_STATUS_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  localparam int unsigned YW = WIDTH + 2;
  localparam logic [YW-1:0] One = YW'(1);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_sel;

  logic             s2_advance;
  logic             accept;
  logic [YW-1:0]    ax;
  logic [YW-1:0]    bx;
  logic [YW-1:0]    res;

  // Handshake control: S2 drains when empty or consumed; S1 frees when it moves on.
  always_comb begin
    s2_advance = ~out_valid | out_ready;
    in_ready   = ~s1_valid | s2_advance;
    accept     = in_valid & in_ready;
  end

  // S1: operands load only on accept so the datapath stays quiet otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= b;
      s1_sel   <= sel;
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Combinational ALU on the zero-extended S1 operands, modulo 2^(W+2).
  always_comb begin
    ax = {2'b00, s1_a};
    bx = {2'b00, s1_b};
    res = '0;
    unique case (s1_sel)
      4'b0000: res = ax + One;
      4'b0001: res = ax - One;
      4'b0010: res = ax << SHAMT_A;
      4'b0011: res = bx + One;
      4'b0100: res = bx - One;
      4'b0101: res = bx << 1;
      4'b0110: res = ax + bx;
      4'b0111: res = ax - bx;
      4'b1000: res = ~ax;
      4'b1001: res = ~bx;
      4'b1010: res = ax & bx;
      4'b1011: res = ax | bx;
      4'b1100: res = ax ^ bx;
      4'b1101: res = ~(ax ^ bx);
      4'b1110: res = ~(ax & bx);
      4'b1111: res = ~(ax | bx);
      default: res = '0;
    endcase
  end

  // S2: result register; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y <= res;
      end
    end
  end

`ifdef ALU_STATUS_FLAGS_EN
  logic [2:0] flags_d;

  // Flags derived from the same result; carry only meaningful for arithmetic ops.
  always_comb begin
    flags_d[2] = res[YW-1];
    flags_d[1] = ~s1_sel[3] & res[WIDTH];
    flags_d[0] = (res == '0);
  end

  // Flags register tracks y exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (s2_advance && s1_valid) begin
      flags <= flags_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipelined.sv
// Self-checking bench for alu_pipelined: vector table plus scoreboard,
// handwritten latency/backpressure/reset sequences and a W=8 shift check.
module tb_alu_pipelined;

  localparam int W  = 4;
  localparam int YW = W + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [3:0]    sel;
  logic [YW-1:0] y;
  logic          in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]    a8, b8;
  logic [3:0]    sel8;
  logic [9:0]    y8;
`ifdef ALU_STATUS_FLAGS_EN
  logic [2:0]    flags, flags8;
`endif

  alu_pipelined #(.WIDTH(W), .SHAMT_A(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready), .y(y)
`ifdef ALU_STATUS_FLAGS_EN
    , .flags(flags)
`endif
  );

  alu_pipelined #(.WIDTH(8), .SHAMT_A(3)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sel(sel8), .out_valid(out_valid8), .out_ready(out_ready8), .y(y8)
`ifdef ALU_STATUS_FLAGS_EN
    , .flags(flags8)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    sel;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [YW-1:0] exp_y;
  } vec_t;

  typedef struct {
    logic [YW-1:0] y;
    logic [3:0]    sel;
  } exp_t;

  localparam int NV = 26;
  vec_t vecs[NV];
  exp_t sb[$];
  exp_t cur;
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   rand_bp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [YW-1:0] model(input logic [3:0] s, input logic [W-1:0] aa,
                                          input logic [W-1:0] bb);
    int x, z, r;
    x = int'(aa);
    z = int'(bb);
    case (s)
      4'd0:  r = x + 1;
      4'd1:  r = x - 1;
      4'd2:  r = x * 4;
      4'd3:  r = z + 1;
      4'd4:  r = z - 1;
      4'd5:  r = z * 2;
      4'd6:  r = x + z;
      4'd7:  r = x - z;
      4'd8:  r = ~x;
      4'd9:  r = ~z;
      4'd10: r = x & z;
      4'd11: r = x | z;
      4'd12: r = x ^ z;
      4'd13: r = ~(x ^ z);
      4'd14: r = ~(x & z);
      default: r = ~(x | z);
    endcase
    return r[YW-1:0];
  endfunction

  function automatic logic [2:0] exp_flags(input logic [YW-1:0] ey, input logic [3:0] s);
    return {ey[YW-1], s[3] ? 1'b0 : ey[W], ey == '0};
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: handshakes evaluated mid-cycle, transfers happen at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_y", {26'd0, y}, {26'd0, e.y});
`ifdef ALU_STATUS_FLAGS_EN
          check("sb_flags", {29'd0, flags}, {29'd0, exp_flags(e.y, e.sel)});
`endif
        end
      end
      if (in_valid && in_ready) sb.push_back(cur);
    end
  end

  task automatic send(input logic [3:0] s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic [YW-1:0] ey);
    int n = 0;
    sel = s; a = aa; b = bb;
    cur.y = ey; cur.sel = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    int c0, n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sel8 = '0; out_ready8 = 1'b1;
    // a=1011, b=0110 across all opcodes, then boundary and named cases
    vecs[0]  = '{4'b0000, 4'hB, 4'h6, 6'b001100};
    vecs[1]  = '{4'b0001, 4'hB, 4'h6, 6'b001010};
    vecs[2]  = '{4'b0010, 4'hB, 4'h6, 6'b101100};
    vecs[3]  = '{4'b0011, 4'hB, 4'h6, 6'b000111};
    vecs[4]  = '{4'b0100, 4'hB, 4'h6, 6'b000101};
    vecs[5]  = '{4'b0101, 4'hB, 4'h6, 6'b001100};
    vecs[6]  = '{4'b0110, 4'hB, 4'h6, 6'b010001};
    vecs[7]  = '{4'b0111, 4'hB, 4'h6, 6'b000101};
    vecs[8]  = '{4'b1000, 4'hB, 4'h6, 6'b110100};
    vecs[9]  = '{4'b1001, 4'hB, 4'h6, 6'b111001};
    vecs[10] = '{4'b1010, 4'hB, 4'h6, 6'b000010};
    vecs[11] = '{4'b1011, 4'hB, 4'h6, 6'b001111};
    vecs[12] = '{4'b1100, 4'hB, 4'h6, 6'b001101};
    vecs[13] = '{4'b1101, 4'hB, 4'h6, 6'b110010};
    vecs[14] = '{4'b1110, 4'hB, 4'h6, 6'b111101};
    vecs[15] = '{4'b1111, 4'hB, 4'h6, 6'b110000};
    vecs[16] = '{4'b0000, 4'h2, 4'h1, 6'b000011};
    vecs[17] = '{4'b0110, 4'h2, 4'h3, 6'b000101};
    vecs[18] = '{4'b0111, 4'h2, 4'h3, 6'b111111};
    vecs[19] = '{4'b1111, 4'h2, 4'h3, 6'b111100};
    vecs[20] = '{4'b0001, 4'h0, 4'h5, 6'b111111};
    vecs[21] = '{4'b0111, 4'h0, 4'hF, 6'b110001};
    vecs[22] = '{4'b0010, 4'hF, 4'h0, 6'b111100};
    vecs[23] = '{4'b0101, 4'h0, 4'hF, 6'b011110};
    vecs[24] = '{4'b0110, 4'hF, 4'h1, 6'b010000};
    vecs[25] = '{4'b1010, 4'h4, 4'h3, 6'b000000};

    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {26'd0, y}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency: accepted on first edge after reset release, valid two edges later.
    sel = 4'b0000; a = 4'h2; b = 4'h1; cur.y = 6'b000011; cur.sel = 4'b0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_edge1_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_edge2_out_valid", {31'd0, out_valid}, 32'd1);
    check("lat_y", {26'd0, y}, 32'h03);
    @(posedge clk); #1;
    check("lat_after_out_valid", {31'd0, out_valid}, 32'd0);

    // Table back-to-back: one accept per cycle expected.
    c0 = cyc;
    for (int i = 0; i < NV; i++) send(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp_y);
    check("throughput_cycles", cyc - c0, NV);
    drain();

    // Backpressure: two accepted, third blocked with y held.
    out_ready = 1'b0;
    send(4'b0110, 4'hB, 4'h6, 6'b010001);
    send(4'b0000, 4'hB, 4'h6, 6'b001100);
    sel = 4'b1111; a = 4'h0; b = 4'h0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_y_held", {26'd0, y}, 32'h11);
      @(posedge clk); #1;
      sel = 4'(i); a = 4'(i + 3);
    end
    out_ready = 1'b1;
    send(4'b1010, 4'hB, 4'h6, 6'b000010);
    drain();

    // Reset mid-flight with two ops in the pipe.
    out_ready = 1'b0;
    send(4'b0011, 4'h1, 4'h2, 6'b000011);
    send(4'b0100, 4'h1, 4'h2, 6'b000001);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_y", {26'd0, y}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_stale", {31'd0, out_valid}, 32'd0);

    // Random stream with random consumer stalls.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   rs;
      logic [W-1:0] ra, rb;
      rs = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom);
      send(rs, ra, rb, model(rs, ra, rb));
    end
    rand_bp = 1'b0;
    drain();

    // Wide instance: shift wraps modulo 2^10.
    sel8 = 4'b0010; a8 = 8'hFF; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w8_out_valid", {31'd0, out_valid8}, 32'd1);
    check("w8_shift_y", {22'd0, y8}, 32'h3F8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
